rfsh_scan: RTL

//  Parametrised display-scan controller for the multiplexed 7-segment display.
//  - Divides the system clock into digit slots.
//  - Steps a digit index over N_DIG digits, skipping masked-off digits.
//  - Drives active-low one-hot anodes, with a ghost-suppression blanking

---
 rtl/rfsh_pkg.sv | 32 +++
 rtl/rfsh_scan_if.sv | 39 +++
 rtl/rfsh_presc.sv | 52 +++++
 rtl/rfsh_scan.sv | 139 +++++++++++++
 4 files changed

// File: rtl/rfsh_pkg.sv
// rtl/rfsh_pkg.sv - shared constants and helpers for the display-scan controller
//
// Purpose : default parameter values and width helpers shared by the
//           scan controller, its interface and the modulo counter.
// Ports   : none (package).

package rfsh_pkg;

  localparam int DEF_N_DIG       = 8;
  localparam int DEF_PRESCALE    = 100000;
  localparam int DEF_BLANK_CYC   = 2;
  localparam int DEF_BLINK_TICKS = 250;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rfsh_scan_if.sv
// rtl/rfsh_scan_if.sv - control/status bundle between clock core and scan controller
//
// Purpose : groups the scan enable, digit/blink masks and the scan outputs.
// Signals : rs_en         scan enable
//           rs_dig_mask   1 = digit populated/lit, 0 = skipped
//           rs_blink_mask 1 = digit blinks
//           rs_idx        current digit index (selects segments downstream)
//           rs_an_n       active-low one-hot anodes
//           rs_tick       one-cycle pulse in the first cycle of each slot
//           rs_blink_ph   blink phase, 1 = blinking digits dark
// Modports: master = clock core side, slave = scan controller.

interface rfsh_scan_if
  import rfsh_pkg::*;
#(
  parameter int N_DIG = DEF_N_DIG
);

  localparam int IDX_W = clog2(N_DIG);

  logic             rs_en;
  logic [N_DIG-1:0] rs_dig_mask;
  logic [N_DIG-1:0] rs_blink_mask;
  logic [IDX_W-1:0] rs_idx;
  logic [N_DIG-1:0] rs_an_n;
  logic             rs_tick;
  logic             rs_blink_ph;

  modport master (
    output rs_en, rs_dig_mask, rs_blink_mask,
    input  rs_idx, rs_an_n, rs_tick, rs_blink_ph
  );

  modport slave (
    input  rs_en, rs_dig_mask, rs_blink_mask,
    output rs_idx, rs_an_n, rs_tick, rs_blink_ph
  );

endinterface

// File: rtl/rfsh_presc.sv
// rtl/rfsh_presc.sv - modulo-MOD counter with terminal pulse
//
// Purpose : counts 0..MOD-1 while en=1, wraps to 0 at the terminal count and
//           raises tick (combinational) during the cycle that wraps.
// Ports   : clk    clock, rising edge
//           rst_n  synchronous reset, active-low
//           en     count enable; counter holds when low
//           clr    synchronous clear to 0, overrides en
//           tick   1 while en=1 and count is MOD-1 (the wrapping edge)

module rfsh_presc
  import rfsh_pkg::*;
#(
  parameter int MOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int           W    = cnt_w(MOD);
  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rfsh_scan.sv
// rtl/rfsh_scan.sv - multiplexed 7-segment display scan controller
//
// Purpose : divides rs_clk into digit slots, steps the digit index over the
//           populated digits, and drives active-low one-hot anodes with a
//           blanking interval at the start of each slot and per-digit blink.
// Ports   : rs_clk    system clock, rising edge
//           rs_rst_n  synchronous reset, active-low
//           bus       rfsh_scan_if slave: rs_en, rs_dig_mask, rs_blink_mask in;
//                     rs_idx, rs_an_n, rs_tick, rs_blink_ph out (all registered)

module rfsh_scan
  import rfsh_pkg::*;
#(
  parameter int N_DIG       = DEF_N_DIG,
  parameter int PRESCALE    = DEF_PRESCALE,
  parameter int BLANK_CYC   = DEF_BLANK_CYC,
  parameter int BLINK_TICKS = DEF_BLINK_TICKS
) (
  input  logic          rs_clk,
  input  logic          rs_rst_n,
  rfsh_scan_if.slave    bus
);

  localparam int IDX_W = clog2(N_DIG);
  localparam int BLK_W = cnt_w(BLANK_CYC + 1);
  localparam logic [BLK_W-1:0] BLANK_LOAD = BLK_W'(BLANK_CYC);

  logic             slot_tick;   // prescaler wraps on this edge -> new slot
  logic             blink_wrap;  // this slot tick wraps the blink counter

  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [BLK_W-1:0] blank_q, blank_d;
  logic [N_DIG-1:0] an_q,    an_d;
  logic             tick_q,  tick_d;
  logic             ph_q,    ph_d;

  // Digit slot prescaler; dropping rs_en restarts the slot from zero so the
  // first tick after re-enable lands exactly PRESCALE cycles later.
  rfsh_presc #(
    .MOD (PRESCALE)
  ) u_slot_presc (
    .clk   (rs_clk),
    .rst_n (rs_rst_n),
    .en    (bus.rs_en),
    .clr   (~bus.rs_en),
    .tick  (slot_tick)
  );

  // Blink half-period counter, advanced once per slot.
  rfsh_presc #(
    .MOD (BLINK_TICKS)
  ) u_blink_presc (
    .clk   (rs_clk),
    .rst_n (rs_rst_n),
    .en    (slot_tick),
    .clr   (1'b0),
    .tick  (blink_wrap)
  );

  // Smallest enabled index above cur, else the smallest enabled index;
  // an empty mask keeps cur.
  function automatic logic [IDX_W-1:0] next_idx(
    input logic [IDX_W-1:0] cur,
    input logic [N_DIG-1:0] m
  );
    logic [IDX_W-1:0] up;
    logic [IDX_W-1:0] low;
    logic             up_ok;
    logic             low_ok;
    up     = '0;
    low    = '0;
    up_ok  = 1'b0;
    low_ok = 1'b0;
    // Descending scan: the last hit is the smallest qualifying index.
    for (int i = N_DIG - 1; i >= 0; i--) begin
      if (m[i]) begin
        low    = IDX_W'(i);
        low_ok = 1'b1;
        if (i > int'(cur)) begin
          up    = IDX_W'(i);
          up_ok = 1'b1;
        end
      end
    end
    if (up_ok) begin
      return up;
    end else if (low_ok) begin
      return low;
    end
    return cur;
  endfunction

  always_comb begin
    idx_d   = idx_q;
    blank_d = blank_q;
    ph_d    = ph_q;
    tick_d  = slot_tick;
    an_d    = '1;

    if (slot_tick) begin
      idx_d   = next_idx(idx_q, bus.rs_dig_mask);
      blank_d = BLANK_LOAD;
      if (blink_wrap) begin
        ph_d = ~ph_q;
      end
    end else if (bus.rs_en && (blank_q != '0)) begin
      blank_d = blank_q - 1'b1;
    end

    // Decoded from next-state values so the anode lines up with rs_idx and
    // the blanking interval starts on the same edge as the slot.
    if (bus.rs_en && bus.rs_dig_mask[idx_d] && (blank_d == '0) &&
        !(bus.rs_blink_mask[idx_d] && ph_d)) begin
      an_d[idx_d] = 1'b0;
    end
  end

  always_ff @(posedge rs_clk) begin
    if (!rs_rst_n) begin
      idx_q   <= '0;
      blank_q <= '0;
      an_q    <= '1;
      tick_q  <= 1'b0;
      ph_q    <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      blank_q <= blank_d;
      an_q    <= an_d;
      tick_q  <= tick_d;
      ph_q    <= ph_d;
    end
  end

  assign bus.rs_idx      = idx_q;
  assign bus.rs_an_n     = an_q;
  assign bus.rs_tick     = tick_q;
  assign bus.rs_blink_ph = ph_q;

endmodule
